audiouart_debug_jtag_host: RTL and testbench
============================================

# audioUart_debug_jtag_host

Virtual-JTAG initiator that drives the Nios II debug slave's TAP-side signals from the system clock domain. It accepts one command at a time on a valid/ready interface: a 2-bit instruction plus a 38-bit data word. For each command it generates the full UIR → CDR → SDR → UDR → RTI sequence on a divided-down `vji_tck`, shifting the data word in LSB first. The 38 bits captured from `vji_tdo` are returned on a response channel. Its main use is in-system and bench stimulus of the debug slave without a physical JTAG hub.

## Interface
Parameters:
- `DR_WIDTH`, 38: data register length in bits.
- `IR_WIDTH`, 2: virtual IR width in bits.
- `TCK_DIV`, 4: tck half-period in clk cycles; minimum 1.

Ports:
- `clk` in 1: system clock. The block has one clock.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command; high only in IDLE.
- `cmd_ir` in IR_WIDTH: instruction (0 = ocimem, 1 = trace, 2 = break, 3 = reserved).
- `cmd_data` in DR_WIDTH: word to shift into the slave.
- `rsp_valid` out 1: response present; held until accepted.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_data` out DR_WIDTH: bits captured from tdo; bit 0 is the first bit shifted out.
- `rsp_ir_out` out IR_WIDTH: `vji_ir_out` sampled at the UIR rising edge.
- `vji_tck`, `vji_tdi` out 1: virtual JTAG clock and serial data in.
- `vji_ir_in` out IR_WIDTH: virtual IR value.
- `vji_uir`, `vji_cdr`, `vji_sdr`, `vji_udr`, `vji_rti` out 1: virtual state strobes.
- `vji_tdo` in 1: serial data from the slave.
- `vji_ir_out` in IR_WIDTH: IR capture value from the slave.

## Operation
- **Reset values:** every output is 0 except `cmd_ready`, which is 1. `vji_tck` is low and the FSM is in IDLE.
- **Command handshake:** a command is accepted when `cmd_valid & cmd_ready`. `cmd_ir` and `cmd_data` are latched, and `cmd_ready` drops on the next cycle.
- **State sequence:** IDLE → UIR (1 tck period) → CDR (1) → SDR (DR_WIDTH periods) → UDR (1) → RTI (1) → RESP → IDLE.
- **Strobes:** exactly one `vji_*` strobe is high per period, matching the current state. All strobes are low in IDLE and RESP.
- **IR update:** `vji_ir_in` is loaded with the latched instruction at the start of UIR. It then holds that value until the next UIR or reset.
- **Shifting in SDR:** `vji_tdi` presents `data[k]` for period k, k = 0 … DR_WIDTH-1. `vji_tdo` is sampled into `rsp_data[k]` on the clk cycle in which tck rises.
- **Response:** in RESP, `rsp_valid` is 1 and `rsp_data` / `rsp_ir_out` are stable. When `rsp_valid & rsp_ready`, the FSM returns to IDLE and `cmd_ready` is 1 on the following cycle.
- **Reset mid-operation:** on the next cycle all outputs return to their reset values. Any partial transfer is discarded; no response is produced.
- **Counters:** the bit counter is `$clog2(DR_WIDTH)` bits, and the phase counter is `$clog2(TCK_DIV)` bits (minimum 1 bit). There is no wrap; the bit counter terminates at DR_WIDTH-1.

## Timing
- **tck period:** 2·TCK_DIV clk cycles. The first TCK_DIV cycles of each period are low, the remaining TCK_DIV cycles are high.
- **Falling-edge updates:** state, strobes, `vji_tdi` and `vji_ir_in` change only on the clk cycle in which tck falls, i.e. at the period start. The slave's posedge therefore always sees stable values.
- **Latency:** let the accept be cycle 0. The first period starts at cycle 1. `rsp_valid` rises at cycle 1 + (DR_WIDTH+4)·2·TCK_DIV, which is 337 with the defaults.
- **Throughput:** back-to-back commands require at least one IDLE cycle between `rsp` acceptance and the next command accept.

## Configuration
- **`DBG_HOST_IR_CACHE_EN` defined:**
  - An `ir_valid` flag is cleared by reset and set after any UIR.
  - If `ir_valid` is set and `cmd_ir` equals the current `vji_ir_in`, the UIR period is skipped: the FSM goes IDLE → CDR, and `rsp_ir_out` repeats the previous value.
  - Latency with a skip is 1 + (DR_WIDTH+3)·2·TCK_DIV, which is 329 with the defaults.
- **Undefined:** every command performs UIR.

## Structure
- **Package `audioUart_debug_host_pkg`:** FSM state enum (IDLE, UIR, CDR, SDR, UDR, RTI, RESP), IR code constants, and the default DR_WIDTH.
- **Sub-module `audioUart_debug_host_tck_gen`:** phase counter producing `vji_tck`, a `fall_stb` pulse and a `rise_stb` pulse. It is enabled only outside IDLE and RESP, and holds tck low when disabled.

## Test plan
- **Reset:** assert reset for 3 cycles while mid-idle → all `vji_*` outputs 0, `rsp_valid` 0, `cmd_ready` 1.
- **Single transfer:** slave model captures 38'h3F_0000_0001; send `cmd_ir`=2, `cmd_data`=38'h2A_5555_AAAA → `rsp_data`=38'h3F_0000_0001 and the slave shift register holds 38'h2A_5555_AAAA at UDR. Also check `vji_ir_in`=2 and that `rsp_valid` rises at cycle 337.
- **Backpressure:** hold `rsp_ready`=0 for 10 cycles after `rsp_valid` → `rsp_valid` and `rsp_data` are stable and `cmd_ready` stays 0 until the handshake.
- **Reset mid-SDR:** assert reset at bit 17 → all outputs 0 on the next cycle and no response. A following command then completes correctly.
- **IR cache (`DBG_HOST_IR_CACHE_EN`):** two commands with `cmd_ir`=1 → the second has no `vji_uir` pulse and responds at cycle 329. A third command with `cmd_ir`=0 produces a UIR pulse again.
- **Fastest tck:** `TCK_DIV`=1 → `vji_tck` toggles every clk cycle, `rsp_valid` rises at cycle 85, and the data still matches.

Source files
------------

// File: rtl/audiouart_debug_jtag_host_pkg.sv
// Shared types for the virtual-JTAG debug host: FSM states, virtual IR codes,
// and the default data-register length of the Nios II debug slave.
package audioUart_debug_host_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_UIR,
      ST_CDR,
      ST_SDR,
      ST_UDR,
      ST_RTI,
      ST_RESP
   } host_state_e;

   localparam int DBG_DR_WIDTH = 38;
   localparam int DBG_IR_WIDTH = 2;

   localparam logic [DBG_IR_WIDTH-1:0] IR_OCIMEM = 2'd0;
   localparam logic [DBG_IR_WIDTH-1:0] IR_TRACE  = 2'd1;
   localparam logic [DBG_IR_WIDTH-1:0] IR_BREAK  = 2'd2;
   localparam logic [DBG_IR_WIDTH-1:0] IR_RSVD   = 2'd3;

endpackage

// File: rtl/audiouart_debug_jtag_host_tck_gen.sv
// Divided tck generator: TCK_DIV clk cycles low then TCK_DIV high, with
// single-cycle strobes in the cycle before each tck fall and rise.
module audioUart_debug_host_tck_gen #(
   parameter int TCK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic en_i,
   output logic tck_o,
   output logic fall_stb_o,
   output logic rise_stb_o
);

   localparam int                PH_W    = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
   localparam logic [PH_W-1:0]   PH_LOAD = PH_W'(TCK_DIV - 1);

   logic [PH_W-1:0] ph_q, ph_d;
   logic            tck_q, tck_d;
   logic            run_q, run_d;
   logic            ph_tc;

   // The first fall after enable starts a period immediately, so the first
   // period begins on the cycle after the command is accepted.
   always_comb begin
      ph_tc      = (ph_q == '0);
      fall_stb_o = en_i & (~run_q | (tck_q & ph_tc));
      rise_stb_o = en_i & run_q & ~tck_q & ph_tc;
      ph_d       = ph_q;
      tck_d      = tck_q;
      run_d      = run_q;
      if (!en_i) begin
         ph_d  = '0;
         tck_d = 1'b0;
         run_d = 1'b0;
      end else if (fall_stb_o) begin
         ph_d  = PH_LOAD;
         tck_d = 1'b0;
         run_d = 1'b1;
      end else if (rise_stb_o) begin
         ph_d  = PH_LOAD;
         tck_d = 1'b1;
      end else begin
         ph_d = ph_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ph_q  <= '0;
         tck_q <= 1'b0;
         run_q <= 1'b0;
      end else begin
         ph_q  <= ph_d;
         tck_q <= tck_d;
         run_q <= run_d;
      end
   end

   assign tck_o = tck_q;

endmodule

// File: rtl/audiouart_debug_jtag_host.sv
// Virtual-JTAG initiator for the Nios II debug slave: one command runs
// UIR/CDR/SDR/UDR/RTI on a divided tck. Optional UIR skip: DBG_HOST_IR_CACHE_EN.
//
// state | meaning
// IDLE  | waiting for a command (pending flag marks accepted, not yet started)
// UIR   | one period loading vji_ir_in, samples vji_ir_out at the rise
// CDR   | one period, slave captures its data register
// SDR   | DR_WIDTH periods shifting tdi out and tdo in, LSB first
// UDR   | one period, slave updates from its shift register
// RTI   | one period of run-test-idle
// RESP  | response held until rsp_ready
module audiouart_debug_jtag_host
   import audioUart_debug_host_pkg::*;
#(
   parameter int DR_WIDTH = DBG_DR_WIDTH,
   parameter int IR_WIDTH = DBG_IR_WIDTH,
   parameter int TCK_DIV  = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [IR_WIDTH-1:0] cmd_ir,
   input  logic [DR_WIDTH-1:0] cmd_data,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DR_WIDTH-1:0] rsp_data,
   output logic [IR_WIDTH-1:0] rsp_ir_out,
   output logic                vji_tck,
   output logic                vji_tdi,
   output logic [IR_WIDTH-1:0] vji_ir_in,
   output logic                vji_uir,
   output logic                vji_cdr,
   output logic                vji_sdr,
   output logic                vji_udr,
   output logic                vji_rti,
   input  logic                vji_tdo,
   input  logic [IR_WIDTH-1:0] vji_ir_out
);

   localparam int               BIT_W    = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DR_WIDTH - 1);

   host_state_e         state_q, state_d;
   logic                pend_q, pend_d;
   logic [DR_WIDTH-1:0] sh_q, sh_d;
   logic [DR_WIDTH-1:0] cap_q, cap_d;
   logic [IR_WIDTH-1:0] ir_lat_q, ir_lat_d;
   logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
   logic [IR_WIDTH-1:0] ir_cap_q, ir_cap_d;
   logic                tdi_q, tdi_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic                tck_en, fall_stb, rise_stb;
   logic                cache_hit;

   assign tck_en = pend_q | ((state_q != ST_IDLE) && (state_q != ST_RESP));

   audioUart_debug_host_tck_gen #(
      .TCK_DIV (TCK_DIV)
   ) u_tck_gen (
      .clk        (clk),
      .reset      (reset),
      .en_i       (tck_en),
      .tck_o      (vji_tck),
      .fall_stb_o (fall_stb),
      .rise_stb_o (rise_stb)
   );

`ifdef DBG_HOST_IR_CACHE_EN
   logic ir_valid_q, ir_valid_d;
   assign cache_hit = ir_valid_q && (ir_lat_q == ir_in_q);

   always_comb begin
      ir_valid_d = ir_valid_q;
      if ((state_q == ST_UIR) && fall_stb) ir_valid_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) ir_valid_q <= 1'b0;
      else       ir_valid_q <= ir_valid_d;
   end
`else
   assign cache_hit = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      pend_d   = pend_q;
      sh_d     = sh_q;
      cap_d    = cap_q;
      ir_lat_d = ir_lat_q;
      ir_in_d  = ir_in_q;
      ir_cap_d = ir_cap_q;
      tdi_d    = tdi_q;
      bit_d    = bit_q;
      unique case (state_q)
         ST_IDLE: begin
            if (pend_q) begin
               if (fall_stb) begin
                  pend_d = 1'b0;
                  if (cache_hit) begin
                     state_d = ST_CDR;
                  end else begin
                     state_d = ST_UIR;
                     ir_in_d = ir_lat_q;
                  end
               end
            end else if (cmd_valid) begin
               pend_d   = 1'b1;
               sh_d     = cmd_data;
               ir_lat_d = cmd_ir;
            end
         end
         ST_UIR: begin
            if (rise_stb) ir_cap_d = vji_ir_out;
            if (fall_stb) state_d = ST_CDR;
         end
         ST_CDR: begin
            if (fall_stb) begin
               state_d = ST_SDR;
               bit_d   = '0;
               tdi_d   = sh_q[0];
               sh_d    = sh_q >> 1;
            end
         end
         ST_SDR: begin
            if (rise_stb) cap_d = {vji_tdo, cap_q[DR_WIDTH-1:1]};
            if (fall_stb) begin
               if (bit_q == BIT_LAST) begin
                  state_d = ST_UDR;
                  tdi_d   = 1'b0;
               end else begin
                  bit_d = bit_q + 1'b1;
                  tdi_d = sh_q[0];
                  sh_d  = sh_q >> 1;
               end
            end
         end
         ST_UDR: if (fall_stb) state_d = ST_RTI;
         ST_RTI: if (fall_stb) state_d = ST_RESP;
         ST_RESP: if (rsp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         pend_q   <= 1'b0;
         sh_q     <= '0;
         cap_q    <= '0;
         ir_lat_q <= '0;
         ir_in_q  <= '0;
         ir_cap_q <= '0;
         tdi_q    <= 1'b0;
         bit_q    <= '0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         sh_q     <= sh_d;
         cap_q    <= cap_d;
         ir_lat_q <= ir_lat_d;
         ir_in_q  <= ir_in_d;
         ir_cap_q <= ir_cap_d;
         tdi_q    <= tdi_d;
         bit_q    <= bit_d;
      end
   end

   assign cmd_ready  = (state_q == ST_IDLE) && !pend_q;
   assign rsp_valid  = (state_q == ST_RESP);
   assign rsp_data   = cap_q;
   assign rsp_ir_out = ir_cap_q;
   assign vji_tdi    = tdi_q;
   assign vji_ir_in  = ir_in_q;
   assign vji_uir    = (state_q == ST_UIR);
   assign vji_cdr    = (state_q == ST_CDR);
   assign vji_sdr    = (state_q == ST_SDR);
   assign vji_udr    = (state_q == ST_UDR);
   assign vji_rti    = (state_q == ST_RTI);

endmodule

// File: tb/tb_audiouart_debug_jtag_host.sv
// Bench for the virtual-JTAG host: unit 0 uses TCK_DIV=4, unit 1 TCK_DIV=1,
// each driving a behavioural debug-slave shift register.
module tb_audiouart_debug_jtag_host;

   localparam int W   = 38;
   localparam int IRW = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [1:0] cmd_valid, cmd_ready, rsp_valid, rsp_ready;
   logic [1:0] vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_tdo;
   logic [IRW-1:0] cmd_ir [2];
   logic [IRW-1:0] rsp_ir_out [2];
   logic [IRW-1:0] vji_ir_in [2];
   logic [IRW-1:0] vji_ir_out [2];
   logic [W-1:0]   cmd_data [2];
   logic [W-1:0]   rsp_data [2];
   logic [W-1:0]   sl_cap [2];
   logic [W-1:0]   sl_udr [2];
   int             uir_cnt [2];
   int             sdr_cnt [2];

   int checks = 0;
   int errors = 0;

   // reference model of the host's IR cache state
   logic           m_valid [2];
   logic [IRW-1:0] m_ir [2];
   logic [IRW-1:0] m_rsp_ir [2];

   for (genvar g = 0; g < 2; g++) begin : g_u
      logic [W-1:0] sr      = '0;
      logic [W-1:0] udr_val = '0;
      int           n_uir   = 0;
      int           n_sdr   = 0;

      audiouart_debug_jtag_host #(
         .DR_WIDTH (W),
         .IR_WIDTH (IRW),
         .TCK_DIV  ((g == 0) ? 4 : 1)
      ) u_dut (
         .clk        (clk),
         .reset      (reset),
         .cmd_valid  (cmd_valid[g]),
         .cmd_ready  (cmd_ready[g]),
         .cmd_ir     (cmd_ir[g]),
         .cmd_data   (cmd_data[g]),
         .rsp_valid  (rsp_valid[g]),
         .rsp_ready  (rsp_ready[g]),
         .rsp_data   (rsp_data[g]),
         .rsp_ir_out (rsp_ir_out[g]),
         .vji_tck    (vji_tck[g]),
         .vji_tdi    (vji_tdi[g]),
         .vji_ir_in  (vji_ir_in[g]),
         .vji_uir    (vji_uir[g]),
         .vji_cdr    (vji_cdr[g]),
         .vji_sdr    (vji_sdr[g]),
         .vji_udr    (vji_udr[g]),
         .vji_rti    (vji_rti[g]),
         .vji_tdo    (vji_tdo[g]),
         .vji_ir_out (vji_ir_out[g])
      );

      // slave: capture on CDR, shift toward bit 0 on SDR, snapshot on UDR
      always @(posedge vji_tck[g]) begin
         if (vji_cdr[g]) sr <= sl_cap[g];
         if (vji_sdr[g]) begin
            sr    <= {vji_tdi[g], sr[W-1:1]};
            n_sdr <= n_sdr + 1;
         end
         if (vji_udr[g]) udr_val <= sr;
         if (vji_uir[g]) n_uir <= n_uir + 1;
      end

      assign vji_tdo[g] = sr[0];
      assign sl_udr[g]  = udr_val;
      assign uir_cnt[g] = n_uir;
      assign sdr_cnt[g] = n_sdr;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input int u);
      chk("rst_strobes", 64'({vji_tck[u], vji_tdi[u], vji_uir[u], vji_cdr[u],
                              vji_sdr[u], vji_udr[u], vji_rti[u]}), 64'(0));
      chk("rst_ir_in", 64'(vji_ir_in[u]), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid[u]), 64'(0));
      chk("rst_rsp_data", 64'(rsp_data[u]), 64'(0));
      chk("rst_rsp_ir", 64'(rsp_ir_out[u]), 64'(0));
      chk("rst_cmd_ready", 64'(cmd_ready[u]), 64'(1));
   endtask

   function automatic int exp_latency(input int div, input logic skip);
      return 1 + (W + (skip ? 3 : 4)) * 2 * div;
   endfunction

   function automatic logic [W-1:0] rand_word();
      return W'({$urandom(), $urandom()});
   endfunction

   task automatic run_cmd(input int u, input logic [IRW-1:0] ir, input logic [W-1:0] data,
                          input logic [W-1:0] cap, input int bp);
      int             div, n, rises, multi, stuck, uir0;
      logic           skip, ptck;
      logic [IRW-1:0] ir_o, exp_ir_out;
      div  = (u == 0) ? 4 : 1;
      ir_o = IRW'($urandom_range(0, 3));
      vji_ir_out[u] = ir_o;
      sl_cap[u]     = cap;
      skip = 1'b0;
`ifdef DBG_HOST_IR_CACHE_EN
      skip = m_valid[u] && (m_ir[u] == ir);
`endif
      exp_ir_out = skip ? m_rsp_ir[u] : ir_o;
      uir0 = uir_cnt[u];
      @(negedge clk);
      chk("cmd_ready_idle", 64'(cmd_ready[u]), 64'(1));
      cmd_valid[u] = 1'b1;
      cmd_ir[u]    = ir;
      cmd_data[u]  = data;
      @(posedge clk);
      @(negedge clk);
      cmd_valid[u] = 1'b0;
      chk("cmd_ready_busy", 64'(cmd_ready[u]), 64'(0));
      n = 0; rises = 0; multi = 0; stuck = 0;
      ptck = vji_tck[u];
      while (!rsp_valid[u] && n < 3000) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (vji_tck[u] && !ptck) rises++;
         if (n >= 2 && vji_tck[u] == ptck) stuck++;
         if ($countones({vji_uir[u], vji_cdr[u], vji_sdr[u], vji_udr[u], vji_rti[u]}) > 1) multi++;
         ptck = vji_tck[u];
      end
      chk("rsp_latency", 64'(n), 64'(exp_latency(div, skip)));
      chk("tck_periods", 64'(rises), 64'(W + (skip ? 3 : 4)));
      chk("uir_pulses", 64'(uir_cnt[u] - uir0), 64'(skip ? 0 : 1));
      chk("strobe_onehot", 64'(multi), 64'(0));
      if (u == 1) chk("tck_toggle_every_clk", 64'(stuck), 64'(0));
      chk("rsp_data", 64'(rsp_data[u]), 64'(cap));
      chk("rsp_ir_out", 64'(rsp_ir_out[u]), 64'(exp_ir_out));
      chk("ir_in", 64'(vji_ir_in[u]), 64'(ir));
      chk("slave_udr", 64'(sl_udr[u]), 64'(data));
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         chk("bp_rsp_valid", 64'(rsp_valid[u]), 64'(1));
         chk("bp_rsp_data", 64'(rsp_data[u]), 64'(cap));
         chk("bp_cmd_ready", 64'(cmd_ready[u]), 64'(0));
      end
      rsp_ready[u] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready[u] = 1'b0;
      chk("post_hs_rsp_valid", 64'(rsp_valid[u]), 64'(0));
      chk("post_hs_cmd_ready", 64'(cmd_ready[u]), 64'(1));
      if (!skip) m_rsp_ir[u] = ir_o;
      m_valid[u] = 1'b1;
      m_ir[u]    = ir;
   endtask

   initial begin
      int n, hits, s0;
      reset     = 1'b1;
      cmd_valid = '0;
      rsp_ready = '0;
      for (int u = 0; u < 2; u++) begin
         cmd_ir[u]     = '0;
         cmd_data[u]   = '0;
         vji_ir_out[u] = '0;
         sl_cap[u]     = '0;
         m_valid[u]    = 1'b0;
         m_ir[u]       = '0;
         m_rsp_ir[u]   = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset(0);
      chk_reset(1);
      reset = 1'b0;

      run_cmd(0, 2'd2, 38'h2A_5555_AAAA, 38'h3F_0000_0001, 10);
      for (int i = 0; i < 3; i++)
         run_cmd(0, IRW'($urandom_range(0, 3)), rand_word(), rand_word(), $urandom_range(0, 3));

      run_cmd(0, 2'd1, rand_word(), rand_word(), 0);
      run_cmd(0, 2'd1, rand_word(), rand_word(), 1);
      run_cmd(0, 2'd0, rand_word(), rand_word(), 0);

      // abort a transfer at SDR bit 17
      s0 = sdr_cnt[0];
      sl_cap[0] = rand_word();
      @(negedge clk);
      cmd_valid[0] = 1'b1;
      cmd_ir[0]    = 2'd3;
      cmd_data[0]  = rand_word();
      @(posedge clk);
      @(negedge clk);
      cmd_valid[0] = 1'b0;
      n = 0;
      while ((sdr_cnt[0] - s0) < 17 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("reach_sdr_bit17", 64'(n < 2000), 64'(1));
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk_reset(0);
      chk_reset(1);
      reset = 1'b0;
      m_valid[0] = 1'b0;
      m_valid[1] = 1'b0;
      hits = 0;
      repeat (400) begin
         @(negedge clk);
         if (rsp_valid[0]) hits++;
      end
      chk("no_rsp_after_abort", 64'(hits), 64'(0));
      run_cmd(0, 2'd3, rand_word(), rand_word(), 2);

      run_cmd(1, 2'd2, 38'h2A_5555_AAAA, 38'h3F_0000_0001, 3);
      for (int i = 0; i < 4; i++)
         run_cmd(1, IRW'($urandom_range(0, 3)), rand_word(), rand_word(), $urandom_range(0, 2));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
